// File: rtl/clock_divider_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_divider_bank_if
// Description : Control and output bundle for clock_divider_bank. The master
//               side drives the enables and divisor-load strobe. The slave
//               side returns the ticks, square waves and pixel clock.
// Revision    : 1.0  initial release
// ============================================================================
interface clock_divider_bank_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 22
);
    logic [NUM_CH-1:0] ch_en;
    logic              div_load;
    logic [2:0]        div_sel;
    logic [CNT_W-1:0]  div_value;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] update;
    logic              pix_clk;
    logic              pix_tick;

    modport master (
        output ch_en, div_load, div_sel, div_value,
        input  tick, update, pix_clk, pix_tick
    );

    modport slave (
        input  ch_en, div_load, div_sel, div_value,
        output tick, update, pix_clk, pix_tick
    );
endinterface
`default_nettype wire

// File: rtl/clock_divider_bank.sv
`default_nettype none
// ============================================================================
// Module      : clock_divider_bank
// Description : NUM_CH independent tick/square-wave dividers plus a
//               free-running 50%-duty pixel clock, all clocked by board_clk.
//               Define CLKDIV_LOAD_EN to enable runtime divisor loading with
//               glitch-free retiming. Without it, every channel runs at
//               DEFAULT_DIV.
// Revision    : 1.0  initial release
// ============================================================================
module clock_divider_bank #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 22,
    parameter int DEFAULT_DIV = 1250000,
    parameter int PIX_DIV     = 2
) (
    input  wire logic           board_clk,
    input  wire logic           reset,
    clock_divider_bank_if.slave bus
);

    localparam logic [CNT_W-1:0] c_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);
    localparam int               c_PIX_W       = $clog2(PIX_DIV);
    localparam logic [c_PIX_W-1:0] c_PIX_LAST  = c_PIX_W'(PIX_DIV - 1);
    localparam logic [c_PIX_W-1:0] c_PIX_HALF  = c_PIX_W'(PIX_DIV / 2);

    logic [NUM_CH-1:0] w_tick;
    logic [NUM_CH-1:0] w_update;

`ifndef CLKDIV_LOAD_EN
    logic w_unused_cfg;
    assign w_unused_cfg = bus.div_load ^ (^bus.div_sel) ^ (^bus.div_value);
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic             r_tick;
        logic             r_update;
        logic [CNT_W-1:0] w_div_cur;
        logic             w_run;
        logic             w_terminal;
        logic             w_apply_idle;

        assign w_run      = bus.ch_en[i] && (w_div_cur != '0);
        assign w_terminal = w_run && (r_cnt == w_div_cur - c_ONE);

`ifdef CLKDIV_LOAD_EN
        logic [CNT_W-1:0] r_div_cur;
        logic [CNT_W-1:0] r_div_pend;
        logic             r_pend_valid;
        logic             w_sel;

        assign w_div_cur    = r_div_cur;
        assign w_sel        = bus.div_load && (bus.div_sel == 3'(i));
        // A stopped or disabled channel has no period to protect, so a pending divisor lands at once.
        assign w_apply_idle = r_pend_valid && !w_run;

        always_ff @(posedge board_clk) begin
            if (reset) begin
                r_div_cur    <= c_DEFAULT_DIV;
                r_div_pend   <= c_DEFAULT_DIV;
                r_pend_valid <= 1'b0;
            end else begin
                if (r_pend_valid && (w_apply_idle || w_terminal)) begin
                    r_div_cur    <= r_div_pend;
                    r_pend_valid <= 1'b0;
                end
                // A fresh write outranks the clear so a load in the terminal cycle stays pending.
                if (w_sel) begin
                    r_div_pend   <= bus.div_value;
                    r_pend_valid <= 1'b1;
                end
            end
        end
`else
        assign w_div_cur    = c_DEFAULT_DIV;
        assign w_apply_idle = 1'b0;
`endif

        always_ff @(posedge board_clk) begin
            if (reset) begin
                r_cnt    <= '0;
                r_tick   <= 1'b0;
                r_update <= 1'b0;
            end else if (w_apply_idle) begin
                r_cnt  <= '0;
                r_tick <= 1'b0;
            end else if (w_terminal) begin
                r_cnt    <= '0;
                r_tick   <= 1'b1;
                r_update <= ~r_update;
            end else if (w_run) begin
                r_cnt  <= r_cnt + c_ONE;
                r_tick <= 1'b0;
            end else begin
                r_tick <= 1'b0;
                if (w_div_cur == '0) begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_tick[i]   = r_tick;
        assign w_update[i] = r_update;
    end

    assign bus.tick   = w_tick;
    assign bus.update = w_update;

    logic [c_PIX_W-1:0] r_pix_cnt;
    logic [c_PIX_W-1:0] w_pix_nxt;
    logic               r_pix_clk;
    logic               r_pix_tick;

    assign w_pix_nxt = (r_pix_cnt == c_PIX_LAST) ? '0 : r_pix_cnt + c_PIX_W'(1);

    // The outputs are decoded from the next count so that they stay registered while aligned with it.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            r_pix_cnt  <= '0;
            r_pix_clk  <= 1'b0;
            r_pix_tick <= 1'b0;
        end else begin
            r_pix_cnt  <= w_pix_nxt;
            r_pix_clk  <= (w_pix_nxt >= c_PIX_HALF);
            r_pix_tick <= (w_pix_nxt == c_PIX_HALF);
        end
    end

    assign bus.pix_clk  = r_pix_clk;
    assign bus.pix_tick = r_pix_tick;

endmodule
`default_nettype wire
